// File: rtl/tm_netlist_pkg.sv
// Shared constants and clause-index helper for the tm_netlist_0 clause block.
// Holds the literal count, the clause tap offsets and the modular index function.
package tm_netlist_pkg;

  localparam int N_LIT   = 62;
  localparam int OFF_NEG = 1;
  localparam int OFF_POS = 31;

  function automatic int idx(input int j, input int off);
    return (j + off) % N_LIT;
  endfunction

endpackage

// File: rtl/tm_netlist_0_clause.sv
// tm_clause3: one three-literal clause, pos & ~neg & aux.
// Ports: pos, neg, aux literals in; c clause result out.
module tm_clause3 (
  input  logic pos,
  input  logic neg,
  input  logic aux,
  output logic c
);

  assign c = pos & ~neg & aux;

endmodule

// File: rtl/tm_netlist_0.sv
// tm_netlist_0: registers 62 literals, evaluates 62 fixed clauses, registers results.
// Ports: clk, rst (sync active-low), in0..in61 literals, out0..out61 clause flops.
module tm_netlist_0
  import tm_netlist_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in0, in1, in2, in3, in4, in5, in6, in7,
  input  logic in8, in9, in10, in11, in12, in13, in14, in15,
  input  logic in16, in17, in18, in19, in20, in21, in22, in23,
  input  logic in24, in25, in26, in27, in28, in29, in30, in31,
  input  logic in32, in33, in34, in35, in36, in37, in38, in39,
  input  logic in40, in41, in42, in43, in44, in45, in46, in47,
  input  logic in48, in49, in50, in51, in52, in53, in54, in55,
  input  logic in56, in57, in58, in59, in60, in61,
  output logic out0, out1, out2, out3, out4, out5, out6, out7,
  output logic out8, out9, out10, out11, out12, out13, out14, out15,
  output logic out16, out17, out18, out19, out20, out21, out22, out23,
  output logic out24, out25, out26, out27, out28, out29, out30, out31,
  output logic out32, out33, out34, out35, out36, out37, out38, out39,
  output logic out40, out41, out42, out43, out44, out45, out46, out47,
  output logic out48, out49, out50, out51, out52, out53, out54, out55,
  output logic out56, out57, out58, out59, out60, out61
);

  logic [N_LIT-1:0] x_d;
  logic [N_LIT-1:0] x;
  logic [N_LIT-1:0] c;
  logic [N_LIT-1:0] y;

  assign x_d = {
    in61, in60, in59, in58, in57, in56,
    in55, in54, in53, in52, in51, in50, in49, in48,
    in47, in46, in45, in44, in43, in42, in41, in40,
    in39, in38, in37, in36, in35, in34, in33, in32,
    in31, in30, in29, in28, in27, in26, in25, in24,
    in23, in22, in21, in20, in19, in18, in17, in16,
    in15, in14, in13, in12, in11, in10, in9, in8,
    in7, in6, in5, in4, in3, in2, in1, in0
  };

  always_ff @(posedge clk) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_d;
      y <= c;
    end
  end

  // Taps wrap modulo N_LIT so every clause sees three distinct literals.
  for (genvar j = 0; j < N_LIT; j++) begin : g_cl
    tm_clause3 u_cl (
      .pos (x[j]),
      .neg (x[idx(j, OFF_NEG)]),
      .aux (x[idx(j, OFF_POS)]),
      .c   (c[j])
    );
  end

  assign {
    out61, out60, out59, out58, out57, out56,
    out55, out54, out53, out52, out51, out50, out49, out48,
    out47, out46, out45, out44, out43, out42, out41, out40,
    out39, out38, out37, out36, out35, out34, out33, out32,
    out31, out30, out29, out28, out27, out26, out25, out24,
    out23, out22, out21, out20, out19, out18, out17, out16,
    out15, out14, out13, out12, out11, out10, out9, out8,
    out7, out6, out5, out4, out3, out2, out1, out0
  } = y;

endmodule

// File: tb/tb_tm_netlist_0.sv
// Directed and streamed checks of the tm_netlist_0 two-stage clause block.
// Drives the 62 literals from a packed vector and collects the 62 outputs.
module tb_tm_netlist_0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [61:0] vin = '0;
  logic [61:0] vout;
  int total = 0;
  int bad = 0;

  always #1000 clk = ~clk;

  tm_netlist_0 dut (
    .clk(clk), .rst(rst),
    .in0(vin[0]), .in1(vin[1]), .in2(vin[2]), .in3(vin[3]),
    .in4(vin[4]), .in5(vin[5]), .in6(vin[6]), .in7(vin[7]),
    .in8(vin[8]), .in9(vin[9]), .in10(vin[10]), .in11(vin[11]),
    .in12(vin[12]), .in13(vin[13]), .in14(vin[14]), .in15(vin[15]),
    .in16(vin[16]), .in17(vin[17]), .in18(vin[18]), .in19(vin[19]),
    .in20(vin[20]), .in21(vin[21]), .in22(vin[22]), .in23(vin[23]),
    .in24(vin[24]), .in25(vin[25]), .in26(vin[26]), .in27(vin[27]),
    .in28(vin[28]), .in29(vin[29]), .in30(vin[30]), .in31(vin[31]),
    .in32(vin[32]), .in33(vin[33]), .in34(vin[34]), .in35(vin[35]),
    .in36(vin[36]), .in37(vin[37]), .in38(vin[38]), .in39(vin[39]),
    .in40(vin[40]), .in41(vin[41]), .in42(vin[42]), .in43(vin[43]),
    .in44(vin[44]), .in45(vin[45]), .in46(vin[46]), .in47(vin[47]),
    .in48(vin[48]), .in49(vin[49]), .in50(vin[50]), .in51(vin[51]),
    .in52(vin[52]), .in53(vin[53]), .in54(vin[54]), .in55(vin[55]),
    .in56(vin[56]), .in57(vin[57]), .in58(vin[58]), .in59(vin[59]),
    .in60(vin[60]), .in61(vin[61]),
    .out0(vout[0]), .out1(vout[1]), .out2(vout[2]), .out3(vout[3]),
    .out4(vout[4]), .out5(vout[5]), .out6(vout[6]), .out7(vout[7]),
    .out8(vout[8]), .out9(vout[9]), .out10(vout[10]), .out11(vout[11]),
    .out12(vout[12]), .out13(vout[13]), .out14(vout[14]), .out15(vout[15]),
    .out16(vout[16]), .out17(vout[17]), .out18(vout[18]), .out19(vout[19]),
    .out20(vout[20]), .out21(vout[21]), .out22(vout[22]), .out23(vout[23]),
    .out24(vout[24]), .out25(vout[25]), .out26(vout[26]), .out27(vout[27]),
    .out28(vout[28]), .out29(vout[29]), .out30(vout[30]), .out31(vout[31]),
    .out32(vout[32]), .out33(vout[33]), .out34(vout[34]), .out35(vout[35]),
    .out36(vout[36]), .out37(vout[37]), .out38(vout[38]), .out39(vout[39]),
    .out40(vout[40]), .out41(vout[41]), .out42(vout[42]), .out43(vout[43]),
    .out44(vout[44]), .out45(vout[45]), .out46(vout[46]), .out47(vout[47]),
    .out48(vout[48]), .out49(vout[49]), .out50(vout[50]), .out51(vout[51]),
    .out52(vout[52]), .out53(vout[53]), .out54(vout[54]), .out55(vout[55]),
    .out56(vout[56]), .out57(vout[57]), .out58(vout[58]), .out59(vout[59]),
    .out60(vout[60]), .out61(vout[61])
  );

  localparam logic [61:0] V_SINGLE = 62'h0000_0000_8000_0001;
  localparam logic [61:0] V_WRAP   = 62'h2000_0000_4000_0000;
  localparam logic [61:0] V_WRAP0  = 62'h2000_0000_4000_0001;
  localparam logic [61:0] E_WRAP0  = 62'h0000_0000_4000_0000;

  // Reference: c = x & ~rot_right(x,1) & rot_right(x,31).
  function automatic logic [61:0] ref_c(input logic [61:0] v);
    logic [61:0] r1;
    logic [61:0] r31;
    r1  = {v[0], v[61:1]};
    r31 = {v[30:0], v[61:31]};
    return v & ~r1 & r31;
  endfunction

  function automatic logic [61:0] rnd62();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[61:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vin = rnd62();
      tick();
      total++;
      if (vout !== 62'd0) begin
        bad++;
        $display("FAIL reset_hold%0d got=%h want=0", i, vout);
      end
    end
    rst = 1'b1;
    vin = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (vout !== 62'd0) begin
        bad++;
        $display("FAIL reset_zero_in%0d got=%h want=0", i, vout);
      end
    end
  endtask

  task automatic test_single();
    vin = V_SINGLE;
    tick();
    total++;
    if (vout !== 62'd0) begin
      bad++;
      $display("FAIL single_lat1 got=%h want=0", vout);
    end
    tick();
    total++;
    if (vout !== V_SINGLE) begin
      bad++;
      $display("FAIL single_lat2 got=%h want=%h", vout, V_SINGLE);
    end
  endtask

  task automatic test_all_ones();
    vin = '1;
    tick();
    tick();
    total++;
    if (vout !== 62'd0) begin
      bad++;
      $display("FAIL all_ones got=%h want=0", vout);
    end
  endtask

  task automatic test_wrap();
    vin = V_WRAP;
    tick();
    tick();
    total++;
    if (vout !== V_WRAP) begin
      bad++;
      $display("FAIL wrap61 got=%h want=%h", vout, V_WRAP);
    end
    vin = V_WRAP0;
    tick();
    tick();
    total++;
    if (vout !== E_WRAP0) begin
      bad++;
      $display("FAIL wrap61_neg got=%h want=%h", vout, E_WRAP0);
    end
  endtask

  task automatic test_stream();
    logic [61:0] prev;
    logic [61:0] exp;
    int errs;
    errs = 0;
    prev = vin;
    for (int i = 0; i < 1000; i++) begin
      vin = rnd62();
      tick();
      exp = ref_c(prev);
      total++;
      if (vout !== exp) begin
        bad++;
        errs++;
        if (errs <= 5)
          $display("FAIL stream%0d got=%h want=%h", i, vout, exp);
      end
      prev = vin;
    end
  endtask

  task automatic test_mid_reset();
    vin = V_SINGLE;
    tick();
    vin = V_SINGLE;
    rst = 1'b0;
    tick();
    total++;
    if (vout !== 62'd0) begin
      bad++;
      $display("FAIL midrst_edge got=%h want=0", vout);
    end
    rst = 1'b1;
    vin = V_WRAP;
    tick();
    total++;
    if (vout !== 62'd0) begin
      bad++;
      $display("FAIL midrst_next got=%h want=0", vout);
    end
    vin = '0;
    tick();
    total++;
    if (vout !== V_WRAP) begin
      bad++;
      $display("FAIL midrst_resume got=%h want=%h", vout, V_WRAP);
    end
    tick();
    total++;
    if (vout !== 62'd0) begin
      bad++;
      $display("FAIL midrst_zero got=%h want=0", vout);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_ones();
    test_wrap();
    test_stream();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
